mitm_mode_scheduler: RTL and testbench

//  Owns the active MITM mode of the UART datapath and gates mode changes.
//  - Accepts debounced mode-select presses.
//  - Applies a mode change only while both interfaces are quiet.
//  - Quiet means no traffic for a full inter-session gap.
//  - A mode never switches mid-frame or mid-session.
//  - Sits between the button debouncer and the UART MITM datapath; drives the mode LEDs and comm-active LED.

---
 rtl/mitm_mode_scheduler.sv | 139 +++++++++++++
 tb/tb_mitm_mode_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mitm_mode_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mitm_mode_scheduler: holds the MITM mode, defers presses until quiet bus |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mitm_mode_scheduler #(
  parameter int NUM_MITM_MODES = 4,
  parameter int SYS_FREQ_HZ    = 12_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int IDLE_GAP_BITS  = 12,
  localparam int MW            = $clog2(NUM_MITM_MODES)
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      mode_next,
  input  logic                      if0_busy,
  input  logic                      if1_busy,
  output logic [MW-1:0]             mode_idx,
  output logic [NUM_MITM_MODES-1:0] mode_leds,
  output logic                      comm_active,
  output logic                      mode_pending,
  output logic                      mode_changed
);

  localparam int GAP_CYCLES = int'((longint'(SYS_FREQ_HZ) * longint'(IDLE_GAP_BITS))
                                   / longint'(BAUD_RATE));
  localparam int GW         = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [MW:0]   N_W      = (MW+1)'(NUM_MITM_MODES);
  localparam logic [MW-1:0] MODE_TOP = MW'(NUM_MITM_MODES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
  logic [MW-1:0]             pend_q, pend_d;
  logic [MW-1:0]             mode_q, mode_d;
  logic [NUM_MITM_MODES-1:0] leds_q, leds_d;
  logic                      pending_q, pending_d;
  logic                      changed_q, changed_d;

  logic          busy;
  logic          eligible;
  logic [MW-1:0] pend_inc;
  logic [MW:0]   delta;
  logic [MW:0]   sum;
  logic [MW:0]   sum_mod;
  logic          delta_null;

  assign busy     = if0_busy | if1_busy;
  assign eligible = (state_q == S_IDLE) && !busy;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (busy) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!busy) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (busy) begin
          state_d   = S_ACTIVE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  // delta never exceeds N and the sum never exceeds 2N-1, so one
  // conditional subtraction is a full modulo for any mode count.
  always_comb begin
    pend_inc   = (pend_q == MODE_TOP) ? '0 : pend_q + 1'b1;
    delta      = {1'b0, pend_q} + {{MW{1'b0}}, mode_next};
    sum        = {1'b0, mode_q} + delta;
    sum_mod    = (sum >= N_W) ? (sum - N_W) : sum;
    delta_null = (delta == '0) || (delta == N_W);

    pend_d    = pend_q;
    mode_d    = mode_q;
    changed_d = 1'b0;
    if (eligible) begin
      pend_d = '0;
      if (!delta_null) begin
        mode_d    = sum_mod[MW-1:0];
        changed_d = 1'b1;
      end
    end else if (mode_next) begin
      pend_d = pend_inc;
    end
    leds_d    = {{(NUM_MITM_MODES-1){1'b0}}, 1'b1} << mode_d;
    pending_d = (pend_d != '0);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      pend_q    <= '0;
      mode_q    <= '0;
      leds_q    <= {{(NUM_MITM_MODES-1){1'b0}}, 1'b1};
      pending_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      leds_q    <= leds_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
    end
  end

  assign mode_idx     = mode_q;
  assign mode_leds    = leds_q;
  assign comm_active  = (state_q != S_IDLE);
  assign mode_pending = pending_q;
  assign mode_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_mitm_mode_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mitm_mode_scheduler: directed + random checks against a session model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mitm_mode_scheduler;

  localparam int N   = 4;
  localparam int GAP = 12_000_000 * 12 / 115_200;

  logic       sys_clk;
  logic       rst_n;
  logic       mode_next;
  logic       if0_busy;
  logic       if1_busy;
  logic [1:0] mode_idx;
  logic [3:0] mode_leds;
  logic       comm_active;
  logic       mode_pending;
  logic       mode_changed;

  mitm_mode_scheduler #(
    .NUM_MITM_MODES(N),
    .SYS_FREQ_HZ   (12_000_000),
    .BAUD_RATE     (115_200),
    .IDLE_GAP_BITS (12)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .mode_next   (mode_next),
    .if0_busy    (if0_busy),
    .if1_busy    (if1_busy),
    .mode_idx    (mode_idx),
    .mode_leds   (mode_leds),
    .comm_active (comm_active),
    .mode_pending(mode_pending),
    .mode_changed(mode_changed)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a session is over once GAP+1 consecutive quiet cycles
  // have been seen; presses are counted and applied as a net rotation.
  int m_mode, m_pend, m_quiet;
  bit m_ever, m_changed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_quiet = 0; m_ever = 0; m_changed = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mode"},    32'(mode_idx),     32'(m_mode));
    chk({tag, ".leds"},    32'(mode_leds),    32'(1) << m_mode);
    chk({tag, ".comm"},    32'(comm_active),  32'(m_ever && (m_quiet < GAP + 1)));
    chk({tag, ".pending"}, 32'(mode_pending), 32'(m_pend != 0));
    chk({tag, ".changed"}, 32'(mode_changed), 32'(m_changed));
  endtask

  task automatic cyc(input bit nx, input bit b0, input bit b1);
    bit busy, elig;
    int d;
    mode_next = nx; if0_busy = b0; if1_busy = b1;
    @(posedge sys_clk);
    busy      = b0 | b1;
    elig      = !busy && (!m_ever || m_quiet >= GAP + 1);
    m_changed = 0;
    if (elig) begin
      d = (m_pend + int'(nx)) % N;
      if (d != 0) begin
        m_mode    = (m_mode + d) % N;
        m_changed = 1;
      end
      m_pend = 0;
    end else begin
      m_pend = (m_pend + int'(nx)) % N;
    end
    if (busy) begin
      m_ever = 1; m_quiet = 0;
    end else if (m_quiet < GAP + 5) begin
      m_quiet++;
    end
    #1;
    check_all("cyc");
  endtask

  initial begin
    int k, pulses, seen_at;
    rst_n = 1'b0; mode_next = 1'b0; if0_busy = 1'b0; if1_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    // 1: reset state
    check_all("reset");
    chk("reset.leds_const", 32'(mode_leds), 32'h1);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    // 2: press while idle lands next cycle
    cyc(1, 0, 0);
    chk("idle_press.mode", 32'(mode_idx), 32'd1);
    chk("idle_press.leds", 32'(mode_leds), 32'h2);
    chk("idle_press.pulse", 32'(mode_changed), 32'd1);
    cyc(0, 0, 0);
    chk("idle_press.pulse_end", 32'(mode_changed), 32'd0);

    // 3: press during traffic deferred GAP+1 cycles after busy falls
    cyc(0, 1, 0); cyc(1, 1, 0);
    chk("defer.pending", 32'(mode_pending), 32'd1);
    repeat (3) cyc(0, 1, 0);
    seen_at = -1;
    for (k = 0; k < GAP + 40 && seen_at < 0; k++) begin
      cyc(0, 0, 0);
      if (mode_changed) seen_at = k;
    end
    chk("defer.latency", 32'(seen_at), 32'(GAP + 1));
    chk("defer.mode", 32'(mode_idx), 32'd2);

    // 4: one-cycle busy at gap count GAP-1 restarts the gap
    cyc(1, 0, 1); cyc(0, 0, 1);
    for (k = 0; k < GAP; k++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("regap.no_change", 32'(mode_idx), 32'd2);
    seen_at = -1;
    for (k = 0; k < GAP + 40 && seen_at < 0; k++) begin
      cyc(0, 0, 0);
      if (mode_changed) seen_at = k;
    end
    chk("regap.latency", 32'(seen_at), 32'(GAP + 1));
    chk("regap.mode", 32'(mode_idx), 32'd3);

    // 5: three presses from mode 3 wrap to 2 in one step; four are net zero
    cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 1); cyc(1, 0, 1);
    pulses = 0;
    for (k = 0; k < GAP + 40; k++) begin
      cyc(0, 0, 0);
      pulses += int'(mode_changed);
    end
    chk("wrap.pulses", 32'(pulses), 32'd1);
    chk("wrap.mode", 32'(mode_idx), 32'd2);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 1); cyc(1, 0, 1);
    chk("net0.pending", 32'(mode_pending), 32'd0);
    pulses = 0;
    for (k = 0; k < GAP + 40; k++) begin
      cyc(0, 0, 0);
      pulses += int'(mode_changed);
    end
    chk("net0.pulses", 32'(pulses), 32'd0);
    chk("net0.mode", 32'(mode_idx), 32'd2);

    // press on the GAP->IDLE transition cycle applies on the following cycle
    cyc(0, 1, 0);
    for (k = 0; k < GAP; k++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("edge_press.held", 32'(mode_idx), 32'd2);
    cyc(0, 0, 0);
    chk("edge_press.pulse", 32'(mode_changed), 32'd1);
    chk("edge_press.mode", 32'(mode_idx), 32'd3);

    // 6: reset mid-gap with two pending presses
    cyc(1, 1, 0); cyc(1, 1, 0);
    for (k = 0; k < 100; k++) cyc(0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("midgap_rst");
    chk("midgap_rst.mode", 32'(mode_idx), 32'd0);
    chk("midgap_rst.comm", 32'(comm_active), 32'd0);
    @(posedge sys_clk);
    #3;
    rst_n = 1'b1;
    pulses = 0;
    for (k = 0; k < GAP + 40; k++) begin
      cyc(0, 0, 0);
      pulses += int'(mode_changed);
    end
    chk("midgap_rst.quiet_pulses", 32'(pulses), 32'd0);

    // randomized sessions, short and full gaps, presses anywhere
    for (int s = 0; s < 12; s++) begin
      int blen, qlen;
      blen = int'($urandom_range(1, 20));
      for (int i = 0; i < blen; i++) begin
        bit a, b;
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        if (!a && !b) a = 1'b1;
        cyc(($urandom_range(0, 3) == 0), a, b);
      end
      qlen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40))
                                         : GAP + int'($urandom_range(0, 40));
      for (int i = 0; i < qlen; i++) cyc(($urandom_range(0, 63) == 0), 0, 0);
      for (int i = 0; i < 8; i++) cyc(($urandom_range(0, 1) == 1), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
